// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes,
// freezes through multi-cycle data-memory accesses (with timeout) and a stall counter.
module pipeline_hazard_controller #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic [1:0]       ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_WriteRegister,
    input  logic             BranchTaken,
    input  logic [1:0]       EX_MEM_MemRead,
    input  logic [1:0]       EX_MEM_MemWrite,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Signal,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Signal,
    output logic             MEM_WB_Signal,
    output logic             MemError,
    output logic [CNT_W-1:0] StallCount,
    output logic [1:0]       State
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic                wait_load, wait_inc, set_err;
    logic                memacc, loaduse;

    assign memacc  = (EX_MEM_MemRead != 2'd0) || (EX_MEM_MemWrite != 2'd0);
    assign loaduse = (ID_EX_MemRead != 2'd0) && (ID_EX_WriteRegister != '0) &&
                     ((ID_EX_WriteRegister == IF_ID_Rs) || (ID_EX_WriteRegister == IF_ID_Rt));

    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Signal  = 1'b0;
        EX_MEM_Write  = 1'b1;
        EX_MEM_Signal = 1'b0;
        MEM_WB_Signal = 1'b0;
        state_d       = state_q;
        wait_load     = 1'b0;
        wait_inc      = 1'b0;
        set_err       = 1'b0;

        if (Reset) begin
            IF_ID_Flush   = 1'b1;
            ID_EX_Signal  = 1'b1;
            EX_MEM_Signal = 1'b1;
            MEM_WB_Signal = 1'b1;
            state_d       = ST_RUN;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    PCWrite       = 1'b0;
                    IF_ID_Write   = 1'b0;
                    ID_EX_Write   = 1'b0;
                    EX_MEM_Write  = 1'b0;
                    MEM_WB_Signal = 1'b1;
                    if (MemReady) begin
                        state_d = ST_RUN;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_d = ST_ABORT;
                        set_err = 1'b1;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                ST_ABORT: begin
                    EX_MEM_Signal = 1'b1;
                    MEM_WB_Signal = 1'b1;
                    state_d       = ST_RUN;
                end
                default: begin
                    // Encoding 3 shares the RUN decode but always falls back to RUN.
                    state_d = ST_RUN;
                    if (memacc && !MemReady) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Write  = 1'b0;
                        MEM_WB_Signal = 1'b1;
                        if (state_q == ST_RUN) begin
                            state_d   = ST_WAIT;
                            wait_load = 1'b1;
                        end
                    end else if (BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Signal = 1'b1;
                    end else if (loaduse) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Signal = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            wait_q     <= '0;
            MemError   <= 1'b0;
            StallCount <= '0;
        end else begin
            state_q <= state_d;
            if (wait_load)
                wait_q <= WAIT_W'(1);
            else if (wait_inc)
                wait_q <= wait_q + WAIT_W'(1);
            if (set_err)
                MemError <= 1'b1;
            if (!PCWrite && (StallCount != '1))
                StallCount <= StallCount + CNT_W'(1);
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: each cycle pushes its expected
// control word / state / error / stall count and pops it when outputs are sampled.
module tb_pipeline_hazard_controller;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Signal, EX_MEM_Write, EX_MEM_Signal, MEM_WB_Signal}
    localparam logic [7:0] C_RST = 8'b1111_1111;
    localparam logic [7:0] C_RUN = 8'b1101_0100;
    localparam logic [7:0] C_FRZ = 8'b0000_0001;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_LU  = 8'b0001_1100;
    localparam logic [7:0] C_ABT = 8'b1101_0111;
    localparam int         CW    = 4;

    typedef struct {
        logic [7:0]    ctrl;
        logic [1:0]    st;
        logic          err;
        logic [CW-1:0] sc;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [4:0]    IF_ID_Rs, IF_ID_Rt, ID_EX_WriteRegister;
    logic [1:0]    ID_EX_MemRead, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic          BranchTaken, MemReady;
    logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Signal;
    logic          EX_MEM_Write, EX_MEM_Signal, MEM_WB_Signal, MemError;
    logic [CW-1:0] StallCount;
    logic [1:0]    State;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_sc = '0;

    always #5 Clock = ~Clock;

    pipeline_hazard_controller #(.REG_W(5), .TIMEOUT(16), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteRegister(ID_EX_WriteRegister),
        .BranchTaken(BranchTaken), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .MemReady(MemReady),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Signal(ID_EX_Signal),
        .EX_MEM_Write(EX_MEM_Write), .EX_MEM_Signal(EX_MEM_Signal),
        .MEM_WB_Signal(MEM_WB_Signal), .MemError(MemError),
        .StallCount(StallCount), .State(State)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] idmr, input logic [4:0] wr, input logic br,
                       input logic [1:0] exr, input logic [1:0] exw, input logic rdy,
                       input logic [7:0] e_ctrl, input logic [1:0] e_st, input logic e_err);
        exp_t e;
        Reset = rst; IF_ID_Rs = rs; IF_ID_Rt = rt; ID_EX_MemRead = idmr;
        ID_EX_WriteRegister = wr; BranchTaken = br; EX_MEM_MemRead = exr;
        EX_MEM_MemWrite = exw; MemReady = rdy;
        sb.push_back('{ctrl: e_ctrl, st: e_st, err: e_err, sc: exp_sc});
        @(negedge Clock);
        e = sb.pop_front();
        check_val({tag, ".ctrl"}, 32'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                   ID_EX_Signal, EX_MEM_Write, EX_MEM_Signal, MEM_WB_Signal}), 32'(e.ctrl));
        check_val({tag, ".state"}, 32'(State), 32'(e.st));
        check_val({tag, ".err"}, 32'(MemError), 32'(e.err));
        check_val({tag, ".stall"}, 32'(StallCount), 32'(e.sc));
        check_val({tag, ".hold_and_flush"}, 32'(!IF_ID_Write && IF_ID_Flush), 32'd0);
        if (rst)
            exp_sc = '0;
        else if (!e.ctrl[7] && exp_sc != '1)
            exp_sc = exp_sc + 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input string tag, input logic [1:0] e_st, input logic e_err);
        cyc(tag, 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, C_RUN, e_st, e_err);
    endtask

    initial begin
        Reset = 1'b1; IF_ID_Rs = '0; IF_ID_Rt = '0; ID_EX_MemRead = '0;
        ID_EX_WriteRegister = '0; BranchTaken = 1'b0; EX_MEM_MemRead = '0;
        EX_MEM_MemWrite = '0; MemReady = 1'b0;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b1, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, C_RST, 2'd0, 1'b0);
        idle("idle", 2'd0, 1'b0);

        cyc("lu_rs", 1'b0, 5'd5, 5'd0, 2'b11, 5'd5, 1'b0, 2'd0, 2'd0, 1'b0, C_LU, 2'd0, 1'b0);
        idle("after_lu", 2'd0, 1'b0);
        cyc("lu_r0", 1'b0, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, C_RUN, 2'd0, 1'b0);
        cyc("lu_nomatch", 1'b0, 5'd3, 5'd4, 2'b01, 5'd7, 1'b0, 2'd0, 2'd0, 1'b0, C_RUN, 2'd0, 1'b0);
        cyc("lu_rt", 1'b0, 5'd1, 5'd7, 2'b01, 5'd7, 1'b0, 2'd0, 2'd0, 1'b0, C_LU, 2'd0, 1'b0);
        cyc("lu_br", 1'b0, 5'd5, 5'd0, 2'b11, 5'd5, 1'b1, 2'd0, 2'd0, 1'b0, C_BR, 2'd0, 1'b0);
        cyc("br", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd0, 2'd0, 1'b0, C_BR, 2'd0, 1'b0);
        cyc("mem_fast", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b1, C_RUN, 2'd0, 1'b0);

        cyc("reset2", 1'b1, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b0, C_RST, 2'd0, 1'b0);
        cyc("mw_entry", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b0, C_FRZ, 2'd0, 1'b0);
        cyc("mw_1", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b0, C_FRZ, 2'd1, 1'b0);
        cyc("mw_ignore", 1'b0, 5'd5, 5'd0, 2'b11, 5'd5, 1'b1, 2'd0, 2'b01, 1'b0, C_FRZ, 2'd1, 1'b0);
        cyc("mw_3", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b0, C_FRZ, 2'd1, 1'b0);
        cyc("mw_ready", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'b01, 1'b1, C_FRZ, 2'd1, 1'b0);
        idle("mw_release", 2'd0, 1'b0);
        check_val("mw_stalls", 32'(StallCount), 32'd5);

        cyc("to_entry", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b10, 2'd0, 1'b0, C_FRZ, 2'd0, 1'b0);
        for (int i = 1; i < 16; i++)
            cyc("to_wait", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b10, 2'd0, 1'b0, C_FRZ, 2'd1, 1'b0);
        cyc("to_abort", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b10, 2'd0, 1'b0, C_ABT, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++)
            idle("sticky", 2'd0, 1'b1);
        check_val("stall_sat", 32'(StallCount), 32'd15);

        cyc("rw_entry", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b01, 2'd0, 1'b0, C_FRZ, 2'd0, 1'b1);
        cyc("rw_wait", 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b01, 2'd0, 1'b0, C_FRZ, 2'd1, 1'b1);
        cyc("rw_reset", 1'b1, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'b01, 2'd0, 1'b0, C_RST, 2'd1, 1'b1);
        idle("rw_after", 2'd0, 1'b0);
        idle("rw_after2", 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
